// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM encoding and packed-bus slice helper.
package ram_arbiter_pkg;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  // Bit offset of element idx in a packed bus of w-bit elements.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first requester after last_grant (wrapping) wins.
module rr_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LG_NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]    req,
  input  logic [LG_NUM_REQ-1:0] last_grant,
  output logic [NUM_REQ-1:0]    grant,
  output logic [LG_NUM_REQ-1:0] grant_id
);

  logic                  found;
  logic [LG_NUM_REQ-1:0] idx;

  // Scan from last_grant+1 around to last_grant itself; lowest-distance valid wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = LG_NUM_REQ'((32'(last_grant) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-requester front end for a single-port synchronous RAM with a clear sweep.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      LG_DEPTH   = 6,
  parameter int unsigned      NUM_REQ    = 4,
  parameter int unsigned      LG_NUM_REQ = 2,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  output logic                         init_done,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*LG_DEPTH-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [LG_DEPTH-1:0]          ram_addr,
  output logic [WIDTH-1:0]             ram_din,
  input  logic [WIDTH-1:0]             ram_dout
);

  state_e                state_q, state_d;
  logic [LG_DEPTH-1:0]   cnt_q, cnt_d;
  logic [LG_NUM_REQ-1:0] last_grant_q;
  logic [NUM_REQ-1:0]    grant;
  logic [LG_NUM_REQ-1:0] grant_id;
  logic                  accept;
  // Read tracking: stage 1 = RAM command issued, stage 2 = RAM data valid.
  logic                  p1_valid_q, p2_valid_q;
  logic [LG_NUM_REQ-1:0] p1_id_q, p2_id_q;

  rr_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .LG_NUM_REQ (LG_NUM_REQ)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // FSM state and sweep counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: sweep all addresses, then run until a clear pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StRun;
      end
      StRun: begin
        if (clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Outputs: grants only in RUN, and not in the cycle a clear is taken.
  always_comb begin
    init_done = (state_q == StRun);
    req_ready = (state_q == StRun && !clear) ? grant : '0;
    accept    = |req_ready;
  end

  // Registered RAM command, round-robin pointer and read-tracking pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_din      <= '0;
      last_grant_q <= LG_NUM_REQ'(NUM_REQ - 1);
      p1_valid_q   <= 1'b0;
      p1_id_q      <= '0;
      p2_valid_q   <= 1'b0;
      p2_id_q      <= '0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      if (state_q == StClear) begin
        ram_en   <= 1'b1;
        ram_we   <= 1'b1;
        ram_addr <= cnt_q;
        ram_din  <= INIT_VAL;
      end else if (accept) begin
        ram_en       <= 1'b1;
        ram_we       <= req_we[grant_id];
        ram_addr     <= req_addr[slice_lsb(32'(grant_id), LG_DEPTH) +: LG_DEPTH];
        ram_din      <= req_wdata[slice_lsb(32'(grant_id), WIDTH) +: WIDTH];
        last_grant_q <= grant_id;
      end
      p1_valid_q <= accept && !req_we[grant_id];
      p1_id_q    <= grant_id;
      p2_valid_q <= p1_valid_q;
      p2_id_q    <= p1_id_q;
    end
  end

  // Response strobe to the owning requester; data passes straight through.
  always_comb begin
    rsp_valid = '0;
    if (p2_valid_q) rsp_valid[p2_id_q] = 1'b1;
    rsp_data = ram_dout;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a 1-cycle synchronous-read RAM model.
module tb_ram_arbiter;

  localparam int W     = 8;
  localparam int LD    = 6;
  localparam int N     = 4;
  localparam int LN    = 2;
  localparam int DEPTH = 64;

  typedef struct {
    int          cyc;
    int          id;
    logic [W-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            init_done;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*LD-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [W-1:0]    rsp_data;
  logic            ram_en, ram_we;
  logic [LD-1:0]   ram_addr;
  logic [W-1:0]    ram_din, ram_dout;

  logic [W-1:0]    mem   [DEPTH];
  logic [W-1:0]    model [DEPTH];
  exp_t            sbq[$];
  exp_t            mon_e;
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .WIDTH      (W),
    .LG_DEPTH   (LD),
    .NUM_REQ    (N),
    .LG_NUM_REQ (LN),
    .INIT_VAL   (8'h00)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Synchronous RAM, preloaded with non-zero garbage so the sweep is observable.
  initial for (int i = 0; i < DEPTH; i++) mem[i] = W'(i * 7 + 3);
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest expected entry, in its exact cycle.
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_valid), 32'(1 << mon_e.id));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  // Present one command from requester id and wait (bounded) for its grant.
  task automatic issue(input int id, input bit we, input int addr, input logic [W-1:0] d);
    int n;
    @(posedge clk); #1;
    req_valid = '0;
    req_we    = '0;
    req_valid[id] = 1'b1;
    req_we[id]    = we;
    req_addr[id*LD +: LD] = LD'(addr);
    req_wdata[id*W +: W]  = d;
    n = 0;
    @(negedge clk);
    while (req_ready === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 32'(req_ready), 32'(1 << id));
    if (req_ready[id] === 1'b1) begin
      if (we) model[addr] = d;
      else sbq.push_back('{cyc + 2, id, model[addr]});
    end
  endtask

  task automatic idle(input int cycles);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (cycles) @(posedge clk);
  endtask

  // Expect a full write sweep 0..DEPTH-1 starting at the first edge from now.
  task automatic check_sweep();
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("sweep", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'({2'b11, LD'(k), W'(0)}));
    end
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", 32'(init_done), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int zero_cnt;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    req_valid = '1;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state, with requests pending to prove no grant leaks out.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram", 32'({ram_en, ram_we, ram_addr, ram_din}), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = '0;
    check_sweep();
    wait_init();

    // Freshly cleared location reads back INIT_VAL; requester 3 keeps last_grant at 3.
    issue(3, 1'b0, 17, 8'h00);
    for (int i = 0; i < N; i++) issue(3, 1'b1, 10 + i, W'(8'h11 * (i + 1)));

    // All four reading at once: grants rotate 0,1,2,3,0 on consecutive cycles.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      req_we[i]    = 1'b0;
      req_addr[i*LD +: LD] = LD'(10 + i);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_order", 32'(req_ready), 32'(1 << (k % N)));
      sbq.push_back('{cyc + 2, k % N, model[10 + (k % N)]});
      @(posedge clk);
    end
    #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // Write then read same address on consecutive cycles returns the new data.
    issue(2, 1'b1, 5, 8'hA5);
    issue(1, 1'b0, 5, 8'h00);
    idle(4);

    // Clear with two reads in flight: both still answered, then sweep blocks grants.
    issue(0, 1'b0, 10, 8'h00);
    issue(1, 1'b0, 11, 8'h00);
    @(posedge clk); #1;
    req_valid    = '0;
    clear        = 1'b1;
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b0;
    req_addr[2*LD +: LD] = LD'(12);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    zero_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (req_ready === '0) zero_cnt++;
      if (k == 10) chk("clear_init_done", 32'(init_done), 32'(0));
      @(posedge clk); #1;
      clear = 1'b0;
    end
    chk("clear_ready_low", 32'(zero_cnt), 32'(64));
    n = 0;
    @(negedge clk);
    while (req_ready === '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("grant_after_clear", 32'(req_ready), 32'(4));
    if (req_ready === 4'b0100) sbq.push_back('{cyc + 2, 2, model[12]});
    idle(4);

    // Reset one cycle after a read accept: the read is abandoned, sweep restarts at 0.
    issue(0, 1'b0, 1, 8'h00);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = '1;
    sbq.delete();
    #1;
    chk("rst2_ram_en", 32'({ram_en, ram_we, ram_addr}), 32'(0));
    chk("rst2_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = '0;
    check_sweep();
    wait_init();

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
